// File: rtl/shift_divide_sequencer.sv
// rtl/shift_divide_sequencer.sv - multi-cycle signed a >>> s sequencer, at most STEP bits per cycle
// Optional: SHIFT_DIVIDE_ROUND_TO_ZERO_EN selects truncation toward zero instead of floor.
module shift_divide_sequencer #(
  parameter int N    = 8,
  parameter int SW   = $clog2(N) + 1,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SW-1:0] N_W    = SW'(N);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);
  localparam logic [N-1:0]  ONES   = '1;
  localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1};

  state_t        state, state_next;
  logic [N-1:0]  acc;
  logic [SW-1:0] rem;
  logic          sticky;
  logic [N-1:0]  result;

  logic [SW-1:0] shift_clamped;
  logic [SW-1:0] k;
  logic [SW-1:0] rem_after;
  logic [N-1:0]  shifted;
  logic          out_or;
  logic          sticky_after;
  logic [N-1:0]  rounded;

  assign shift_clamped = (up_shift > N_W) ? N_W : up_shift;
  assign k             = (rem < STEP_W) ? rem : STEP_W;
  assign rem_after     = rem - k;

  // Only STEP distinct shift distances exist, so the shifter is a STEP-way mux.
  always_comb begin
    shifted = acc;
    out_or  = 1'b0;
    for (int i = 1; i <= STEP; i++) begin
      if (k == SW'(i)) begin
        shifted = N'($signed(acc) >>> i);
        out_or  = |(acc & (ONES >> (N - i)));
      end
    end
  end

  assign sticky_after = sticky | out_or;

`ifdef SHIFT_DIVIDE_ROUND_TO_ZERO_EN
  // Arithmetic shift keeps the operand sign in the MSB, so it marks negative operands.
  assign rounded = (shifted[N-1] && sticky_after) ? shifted + ONE : shifted;
`else
  assign rounded = shifted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        up_ready = 1'b1;
        if (up_valid) state_next = (shift_clamped == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (rem_after == '0) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        down_valid = 1'b1;
        if (down_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      rem    <= '0;
      sticky <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up_valid) begin
            acc    <= up_data;
            rem    <= shift_clamped;
            sticky <= 1'b0;
            if (shift_clamped == '0) result <= up_data;
          end
        end
        SHIFT: begin
          acc    <= shifted;
          rem    <= rem_after;
          sticky <= sticky_after;
          if (rem_after == '0) result <= rounded;
        end
        default: ;
      endcase
    end
  end

  assign down_data = result;

endmodule

// File: tb/tb_shift_divide_sequencer.sv
// tb/tb_shift_divide_sequencer.sv - directed self-checking bench for shift_divide_sequencer
module tb_shift_divide_sequencer;

`ifdef SHIFT_DIVIDE_ROUND_TO_ZERO_EN
  localparam bit RZ = 1'b1;
`else
  localparam bit RZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v1 = 1'b0, r1 = 1'b0, ur1, dv1, busy1;
  logic [7:0] d1 = '0, dd1;
  logic [3:0] s1 = '0;
  logic       v2 = 1'b0, r2 = 1'b0, ur2, dv2, busy2;
  logic [7:0] d2 = '0, dd2;
  logic [3:0] s2 = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_divide_sequencer #(.N(8), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .up_valid(v1), .up_ready(ur1), .up_data(d1), .up_shift(s1),
    .down_valid(dv1), .down_ready(r1), .down_data(dd1), .busy(busy1));

  shift_divide_sequencer #(.N(8), .STEP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .up_valid(v2), .up_ready(ur2), .up_data(d2), .up_shift(s2),
    .down_valid(dv2), .down_ready(r2), .down_data(dd2), .busy(busy2));

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand into dut1; returns once down_valid is seen (down_ready left low).
  task automatic op1(input logic [7:0] data, input logic [3:0] sh, output logic [7:0] res,
                     output int lat);
    @(negedge clk);
    v1 = 1'b1; d1 = data; s1 = sh; r1 = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b0;
    lat = 0;
    while (!dv1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat == 0) lat = 1;
    res = dd1;
  endtask

  task automatic release1();
    @(negedge clk);
    r1 = 1'b1;
    @(posedge clk); #1;
    r1 = 1'b0;
  endtask

  initial begin
    logic [7:0] res;
    logic [7:0] got[$];
    int lat;
    int accepts;
    bit fire_up, fire_dn;
    logic [7:0] snap;

    #2;
    check("reset_up_ready", ur1, 1);
    check("reset_down_valid", dv1, 0);
    check("reset_busy", busy1, 0);
    check("reset_down_data", dd1, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // -27 >>> 3
    op1(8'hE5, 4'd3, res, lat);
    check("e5s3_latency", lat, 3);
    check("e5s3_data", res, RZ ? 8'hFD : 8'hFC);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_down_valid", dv1, 1);
      check("bp_down_data", dd1, RZ ? 8'hFD : 8'hFC);
      check("bp_up_ready", ur1, 0);
    end
    release1();
    check("bp_release_up_ready", ur1, 1);
    check("bp_release_down_valid", dv1, 0);

    // 100 >>> 5 on the STEP=2 instance
    @(negedge clk);
    v2 = 1'b1; d2 = 8'h64; s2 = 4'd5;
    @(posedge clk); #1;
    v2 = 1'b0;
    lat = 0;
    while (!dv2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("s2_64s5_latency", lat, 3);
    check("s2_64s5_data", dd2, 8'h03);
    @(negedge clk); r2 = 1'b1;
    @(posedge clk); #1; r2 = 1'b0;
    check("s2_release_up_ready", ur2, 1);

    op1(8'h80, 4'd0, res, lat);
    check("zero_shift_latency", lat, 1);
    check("zero_shift_data", res, 8'h80);
    release1();

    op1(8'h80, 4'd12, res, lat);
    check("clamp_latency", lat, 8);
    check("clamp_data", res, RZ ? 8'h00 : 8'hFF);
    release1();

    // Back-to-back with up_valid held high
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h40; s1 = 4'd1; r1 = 1'b1;
    accepts = 0;
    for (int c = 0; c < 30 && got.size() < 2; c++) begin
      fire_up = v1 && ur1;
      fire_dn = dv1 && r1;
      snap = dd1;
      @(posedge clk); #1;
      if (fire_dn) got.push_back(snap);
      if (fire_up) begin
        accepts++;
        if (accepts == 1) begin
          d1 = 8'hC0; s1 = 4'd2;
        end else begin
          v1 = 1'b0; d1 = 8'h55; s1 = 4'd7;
        end
      end
      @(negedge clk);
    end
    v1 = 1'b0; r1 = 1'b0;
    check("b2b_count", got.size(), 2);
    check("b2b_accepts", accepts, 2);
    check("b2b_first", (got.size() > 0) ? int'(got[0]) : -1, 8'h20);
    check("b2b_second", (got.size() > 1) ? int'(got[1]) : -1, 8'hF0);

    // Reset in the middle of a 6-step shift
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h7B; s1 = 4'd6;
    @(posedge clk); #1;
    v1 = 1'b0;
    check("mid_busy", busy1, 1);
    check("mid_up_ready", ur1, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_up_ready", ur1, 1);
    check("async_rst_down_valid", dv1, 0);
    check("async_rst_busy", busy1, 0);
    check("async_rst_down_data", dd1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    op1(8'h10, 4'd4, res, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_data", res, 8'h01);
    release1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
